// File: rtl/memory_stage.sv
// MEM stage of the RV32I pipeline: req/ack data-bus master, store lane steering,
// load extension and the MEM/WB register. Optional `MISALIGN_CHECK_EN suppresses misaligned accesses.
module memory_stage #(
  parameter int ADDR_W     = 32,
  parameter int WAIT_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           mem_in_aluOut,
  input  logic [31:0]           mem_in_data2,
  input  logic [4:0]            mem_in_rd,
  input  logic [31:0]           mem_in_immediate,
  input  logic [31:0]           mem_in_imm_plus_pc_or_rs1,
  input  logic [31:0]           mem_in_pc_plus_four,
  input  logic [31:0]           mem_in_instr,
  input  logic                  mem_in_memRead,
  input  logic                  mem_in_memWrite,
  input  logic [2:0]            mem_in_memtoReg,
  input  logic                  mem_in_regWrite,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  mem_out_stall,
  output logic                  mem_out_misaligned,
  output logic [WAIT_CNT_W-1:0] mem_out_wait_cycles,
  output logic [31:0]           wb_aluOut,
  output logic [31:0]           wb_dataMemOut,
  output logic [31:0]           wb_immediate,
  output logic [31:0]           wb_imm_plus_pc_or_rs1,
  output logic [31:0]           wb_pc_plus_four,
  output logic [4:0]            wb_rd,
  output logic [2:0]            wb_memtoReg,
  output logic                  wb_regWrite,
  output logic                  wb_memRead
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;
  state_e state_q, state_d;

  logic [2:0]  funct3;
  logic [1:0]  lane;
  logic        is_half, is_word, op, misaligned, issue;
  logic [31:0] load_ext;
  logic        unused_instr_bits;

  assign funct3  = mem_in_instr[14:12];
  assign lane    = mem_in_aluOut[1:0];
  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = funct3[1];
  assign op      = mem_in_memRead | mem_in_memWrite;
  assign unused_instr_bits = ^{mem_in_instr[31:15], mem_in_instr[11:0]};

`ifdef MISALIGN_CHECK_EN
  assign misaligned = op & ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Reset gates the request combinationally so an in-flight access drops at once.
  assign issue              = op & ~misaligned;
  assign dmem_req           = issue & rst_n;
  assign dmem_we            = dmem_req & mem_in_memWrite;
  assign dmem_addr          = {mem_in_aluOut[ADDR_W-1:2], 2'b00};
  assign mem_out_stall      = dmem_req & ~dmem_ack;
  assign mem_out_misaligned = misaligned;

  always_comb begin
    dmem_wstrb = 4'b0000;
    dmem_wdata = mem_in_data2;
    if (mem_in_memWrite) begin
      if (funct3[1:0] == 2'b00) begin
        dmem_wstrb = 4'b0001 << lane;
        dmem_wdata = {4{mem_in_data2[7:0]}};
      end else if (is_half) begin
        dmem_wstrb = lane[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{mem_in_data2[15:0]}};
      end else begin
        dmem_wstrb = 4'b1111;
      end
    end
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = dmem_rdata[7:0];
    case (lane)
      2'd1:    b = dmem_rdata[15:8];
      2'd2:    b = dmem_rdata[23:16];
      2'd3:    b = dmem_rdata[31:24];
      default: b = dmem_rdata[7:0];
    endcase
    h = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    if (is_word)
      load_ext = dmem_rdata;
    else if (is_half)
      load_ext = {{16{h[15] & ~funct3[2]}}, h};
    else
      load_ext = {{24{b[7] & ~funct3[2]}}, b};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mem_out_stall) state_d = S_WAIT;
      S_WAIT:  if (!mem_out_stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic [31:0] alu_q, alu_d, dmo_q, dmo_d, imm_q, imm_d, ipc_q, ipc_d, pc4_q, pc4_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  m2r_q, m2r_d;
  logic        rw_q, rw_d, mr_q, mr_d;

  always_comb begin
    wait_d = wait_q;
    if (mem_out_stall && !(&wait_q)) wait_d = wait_q + 1'b1;
    alu_d = alu_q; dmo_d = dmo_q; imm_d = imm_q; ipc_d = ipc_q; pc4_d = pc4_q;
    rd_d  = rd_q;  m2r_d = m2r_q; rw_d  = rw_q;  mr_d  = mr_q;
    if (mem_out_stall) begin
      rw_d = 1'b0;
      mr_d = 1'b0;
    end else begin
      alu_d = mem_in_aluOut;
      dmo_d = load_ext;
      imm_d = mem_in_immediate;
      ipc_d = mem_in_imm_plus_pc_or_rs1;
      pc4_d = mem_in_pc_plus_four;
      rd_d  = mem_in_rd;
      m2r_d = mem_in_memtoReg;
      rw_d  = mem_in_regWrite & ~misaligned;
      // Read+write together is handled as a store, so it never writes back load data.
      mr_d  = mem_in_memRead & ~mem_in_memWrite & ~misaligned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      alu_q <= '0; dmo_q <= '0; imm_q <= '0; ipc_q <= '0; pc4_q <= '0;
      rd_q  <= '0; m2r_q <= '0; rw_q  <= 1'b0; mr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      alu_q <= alu_d; dmo_q <= dmo_d; imm_q <= imm_d; ipc_q <= ipc_d; pc4_q <= pc4_d;
      rd_q  <= rd_d;  m2r_q <= m2r_d; rw_q  <= rw_d;  mr_q  <= mr_d;
    end
  end

  assign mem_out_wait_cycles   = wait_q;
  assign wb_aluOut             = alu_q;
  assign wb_dataMemOut         = dmo_q;
  assign wb_immediate          = imm_q;
  assign wb_imm_plus_pc_or_rs1 = ipc_q;
  assign wb_pc_plus_four       = pc4_q;
  assign wb_rd                 = rd_q;
  assign wb_memtoReg           = m2r_q;
  assign wb_regWrite           = rw_q;
  assign wb_memRead            = mr_q;

endmodule
